avr_irq_ctrl: RTL
=================

Name: avr_irq_ctrl

Overview:
- Interrupt controller that sits directly downstream of the single-source peripheral IRQ lines (PENDSV, timers, UART, ...). It consumes their irq outputs and presents one request plus a vector number to the AVR core.
- Per-line mask, per-line level/edge mode, and latched edge pendings, all exposed as an I/O-mapped register bank.
- Fixed priority (lowest index wins). Request/acknowledge handshake with the core.

Parameters:
- N_IRQ, 8, number of IRQ inputs (1..8)
- VEC_W, 3, vector width; must satisfy 2**VEC_W >= N_IRQ

Ports:
- clk, input, 1, system clock
- rst, input, 1, asynchronous active-low reset
- io_a, input, 2, register select
- io_re, input, 1, register read strobe
- io_we, input, 1, register write strobe
- io_do, output, 8, register read data; 0 when io_re=0
- io_di, input, 8, register write data
- irq_in, input, N_IRQ, raw peripheral interrupt lines, active-high
- irq_req, output, 1, interrupt request to core
- irq_vec, output, VEC_W, index of the requested source; valid while irq_req=1
- irq_ack, input, 1, one-cycle core acknowledge of the current request

Behaviour:
- Reset (rst=0, async): MASK=0, EDGE=0, edge pendings=0, prev-input register=0, state=IDLE, irq_req=0, irq_vec=0.
- Registers:
  - io_a=0 PEND: read = effective pending vector. Write is W1C on edge-mode bits; level-mode bits ignore writes.
  - io_a=1 MASK: r/w; 1 = enabled.
  - io_a=2 EDGE: r/w; 1 = rising-edge mode, 0 = level mode.
  - io_a=3: reads 0; writes ignored.
  - Bits at or above N_IRQ read 0.
- Edge pending bit i:
  - Set on the cycle where irq_in[i]=1 and prev[i]=0 (prev is irq_in delayed 1 clk).
  - Cleared by W1C, or by irq_ack when i is the latched vector.
  - Set wins over a same-cycle clear.
- Effective pending[i] = EDGE[i] ? edge_pend[i] : irq_in[i].
- Eligible = pending & MASK. The winner is the lowest set index.
- FSM:
  - IDLE: if eligible != 0, latch the winner into irq_vec and go to REQ; irq_req rises the next cycle. Latency from an input rising to irq_req is 1 clk for level mode and 2 clk for edge mode.
  - REQ: irq_req=1 and irq_vec is held stable, even if the source drops or is masked. On irq_ack: clear that line's edge pending (if edge mode), drop irq_req, go to GAP.
  - GAP: irq_req=0 for exactly one cycle so the source or ISR can deassert; then IDLE. Re-arbitration happens in IDLE only.
- irq_ack while in IDLE or GAP is ignored.
- An MASK/EDGE write takes effect from the next cycle. A request already latched in REQ is not withdrawn.
- Changing EDGE[i] from 1 to 0 clears edge_pend[i].
- Reset mid-REQ: irq_req drops immediately (async), with no ack needed.
- All state is registered; io_do is combinational from the registers.

Decomposition:
- Shared package holds:
  - register offsets: PEND=0, MASK=1, EDGE=2
  - FSM state encoding: IDLE, REQ, GAP
- One natural sub-module, avr_irq_prio: a combinational lowest-index priority encoder (N_IRQ in; VEC_W index and valid out).

Test Plan:
- Reset, MASK=0x01, EDGE=0, drive irq_in=0x01 -> irq_req=1, irq_vec=0 one clk later. Ack -> irq_req=0 for the GAP cycle, then 1 again while the line is still high.
- MASK=0xFF, irq_in=0x28 (level) -> irq_vec=3. Ack, drop bit 3 -> after GAP, irq_vec=5.
- EDGE=0x04, MASK=0x04, pulse irq_in[2] for 1 clk -> PEND reads 0x04 and irq_req rises 2 clk after the pulse. Ack -> PEND reads 0x00.
- Edge pend on bit 1, mask it, write PEND=0x02 -> PEND reads 0x00. Repeat with a rising edge in the same cycle as the W1C -> PEND reads 0x02.
- In REQ with vec=4, drop irq_in[4] and clear MASK -> irq_req stays 1 and irq_vec stays 4 until ack.
- Assert rst=0 asynchronously mid-REQ -> irq_req=0 without a clock edge. MASK, EDGE and PEND read 0 after release.

Source files
------------

// File: rtl/avr_irq_ctrl_pkg.sv
// Shared definitions for the AVR interrupt controller: register map offsets and FSM states.
package avr_irq_ctrl_pkg;

  localparam logic [1:0] RegPend = 2'd0;
  localparam logic [1:0] RegMask = 2'd1;
  localparam logic [1:0] RegEdge = 2'd2;

  localparam int unsigned IoDataW = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StGap  = 2'd2
  } irq_state_e;

endpackage

// File: rtl/avr_irq_prio.sv
// Lowest-index-wins priority encoder; valid is set when any request bit is set.
module avr_irq_prio #(
  parameter int unsigned N_IRQ = 8,
  parameter int unsigned VEC_W = 3
) (
  input  logic [N_IRQ-1:0] req,
  output logic [VEC_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    // Scan high to low so the lowest set index is the last one written.
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/avr_irq_ctrl.sv
// Interrupt controller: per-line mask and level/edge mode, fixed priority, and a
// request/acknowledge handshake with the core, with an I/O-mapped register bank.
module avr_irq_ctrl
  import avr_irq_ctrl_pkg::*;
#(
  parameter int unsigned N_IRQ = 8,
  parameter int unsigned VEC_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         io_a,
  input  logic               io_re,
  input  logic               io_we,
  output logic [7:0]         io_do,
  input  logic [7:0]         io_di,
  input  logic [N_IRQ-1:0]   irq_in,
  output logic               irq_req,
  output logic [VEC_W-1:0]   irq_vec,
  input  logic               irq_ack
);

  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] edge_q, edge_d;
  logic [N_IRQ-1:0] edge_pend_q, edge_pend_d;
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] rise, w1c, ack_clr, edge_off;
  logic [N_IRQ-1:0] pend_eff, eligible;
  logic [N_IRQ-1:0] wr_bits;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [VEC_W-1:0] win_idx;
  logic             win_valid;
  logic             wr_pend, wr_mask, wr_edge;
  irq_state_e       state_q, state_d;

  assign wr_bits = io_di[N_IRQ-1:0];
  assign wr_pend = io_we && (io_a == RegPend);
  assign wr_mask = io_we && (io_a == RegMask);
  assign wr_edge = io_we && (io_a == RegEdge);

  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    if (wr_mask) mask_d = wr_bits;
    if (wr_edge) edge_d = wr_bits;
  end

  assign rise     = irq_in & ~prev_q;
  assign w1c      = wr_pend ? (wr_bits & edge_q) : '0;
  assign edge_off = edge_q & ~edge_d;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < int'(N_IRQ); i++) begin
      if ((state_q == StReq) && irq_ack && (vec_q == VEC_W'(i))) begin
        ack_clr[i] = 1'b1;
      end
    end
  end

  // A fresh edge beats W1C/ack in the same cycle; leaving edge mode always wipes the bit.
  assign edge_pend_d = ((edge_pend_q & ~(w1c | ack_clr)) | (rise & edge_q)) & ~edge_off;

  assign pend_eff = (edge_q & edge_pend_q) | (~edge_q & irq_in);
  assign eligible = pend_eff & mask_q;

  avr_irq_prio #(
    .N_IRQ (N_IRQ),
    .VEC_W (VEC_W)
  ) u_prio (
    .req   (eligible),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          vec_d   = win_idx;
          state_d = StReq;
        end
      end
      StReq: begin
        if (irq_ack) state_d = StGap;
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q      <= '0;
      edge_q      <= '0;
      edge_pend_q <= '0;
      prev_q      <= '0;
      vec_q       <= '0;
      state_q     <= StIdle;
    end else begin
      mask_q      <= mask_d;
      edge_q      <= edge_d;
      edge_pend_q <= edge_pend_d;
      prev_q      <= irq_in;
      vec_q       <= vec_d;
      state_q     <= state_d;
    end
  end

  assign irq_req = (state_q == StReq);
  assign irq_vec = vec_q;

  logic [N_IRQ-1:0]   rd_bits;
  logic [IoDataW-1:0] rd_data;

  always_comb begin
    rd_bits = '0;
    rd_data = '0;
    unique case (io_a)
      RegPend: rd_bits = pend_eff;
      RegMask: rd_bits = mask_q;
      RegEdge: rd_bits = edge_q;
      default: rd_bits = '0;
    endcase
    rd_data[N_IRQ-1:0] = rd_bits;
  end

  assign io_do = io_re ? rd_data : '0;

endmodule
